uart_tx_param: RTL and testbench



---
 rtl/uart_tx_param.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter fed from a small transmit FIFO.
// LSB-first frames, optional parity, 1/2 stop bits, back-to-back output.
module uart_tx_param #(
  parameter int MAIN_CLK   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [DATA_BITS-1:0]            data_in,
  output logic                            ack,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            busy,
  output logic                            tx
);

  localparam int BAUD_DIVIDE = MAIN_CLK / BAUD;
  localparam int CW = $clog2(BAUD_DIVIDE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIVIDE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY == 1) ? 1'b1 : 1'b0;
  localparam logic          HAS_PAR   = (PARITY != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  tx_q, tx_d;

  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  head;
  logic [LW-1:0]         lvl;
  logic                  is_full;
  logic                  has_word;
  logic                  push;
  logic                  pop;
  logic                  tick;

  assign lvl      = wr_ptr_q - rd_ptr_q;
  assign is_full  = (lvl == DEPTH_L);
  assign has_word = (lvl != '0);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign push     = en & ~is_full;
  assign tick     = (baud_q == BAUD_LAST);

  // next-state: bit timing, frame sequencing and FIFO pointer moves
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pop      = 1'b0;
    if (state_q != S_IDLE) begin
      baud_d = tick ? '0 : baud_q + CW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (has_word) pop = 1'b1;
      end
      S_START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            if (has_word) pop = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a pop always starts a fresh frame straight into START
    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ PAR_ODD;
      baud_d  = '0;
      bit_d   = '0;
      state_d = S_START;
    end
    wr_ptr_d = wr_ptr_q + LW'(push);
    rd_ptr_d = rd_ptr_q + LW'(pop);
    ack_d    = push;
    busy_d   = (state_d != S_IDLE);
  end

  // line level follows the current state, one clock behind it
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  // state, counters, pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      tx_q     <= tx_d;
    end
  end

  assign ack   = ack_q;
  assign full  = is_full;
  assign level = lvl;
  assign busy  = busy_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for uart_tx_param.
// Three instances: 8N1, 8E1 and 7O2, all at 10 clocks per bit.
module tb_uart_tx_param;

  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       b2b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst0_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_cnt = 0;
  always @(negedge rst0_n) rst_cnt <= rst_cnt + 1;

  int total = 0;
  int bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic       en0, en1, en2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       ack0, ack1, ack2;
  logic       full0, full1, full2;
  logic [2:0] lvl0, lvl1, lvl2;
  logic       busy0, busy1, busy2;
  logic       tx0, tx1, tx2;
  logic [2:0] txv;
  assign txv = {tx2, tx1, tx0};

  uart_tx_param #(
    .MAIN_CLK(1000000), .BAUD(100000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst_n(rst0_n), .en(en0), .data_in(d0),
    .ack(ack0), .full(full0), .level(lvl0), .busy(busy0), .tx(tx0)
  );

  uart_tx_param #(
    .MAIN_CLK(1000000), .BAUD(100000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .data_in(d1),
    .ack(ack1), .full(full1), .level(lvl1), .busy(busy1), .tx(tx1)
  );

  uart_tx_param #(
    .MAIN_CLK(1000000), .BAUD(100000), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .data_in(d2),
    .ack(ack2), .full(full2), .level(lvl2), .busy(busy2), .tx(tx2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic p,
                              input logic b);
    exp_t e;
    e.d = d;
    e.p = p;
    e.b2b = b;
    return e;
  endfunction

  task automatic pop_exp(input int k, output bit have, output exp_t e);
    have = 1'b0;
    e = '0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default:
        if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
  endtask

  // serial monitor: decodes each frame mid-bit and scores it
  task automatic mon(input int k, input int db, input bit hp,
                     input int sb, input int fl);
    logic [8:0] d;
    logic p;
    bit fr_ok, have;
    int st, last, rs;
    exp_t e;
    last = -100000;
    forever begin
      @(negedge clk);
      if (txv[k] == 1'b0) begin
        st = cyc;
        rs = rst_cnt;
        fr_ok = 1'b1;
        d = '0;
        p = 1'b0;
        repeat (5) @(negedge clk);
        if (txv[k] != 1'b0) fr_ok = 1'b0;
        for (int i = 0; i < db; i++) begin
          repeat (10) @(negedge clk);
          d[i] = txv[k];
        end
        if (hp) begin
          repeat (10) @(negedge clk);
          p = txv[k];
        end
        for (int i = 0; i < sb; i++) begin
          repeat (10) @(negedge clk);
          if (txv[k] != 1'b1) fr_ok = 1'b0;
        end
        if (k != 0 || rs == rst_cnt) begin
          pop_exp(k, have, e);
          chk($sformatf("m%0d_expected", k), int'(have), 1);
          if (have) begin
            chk($sformatf("m%0d_data", k), int'(d), int'(e.d));
            if (hp) chk($sformatf("m%0d_parity", k), int'(p), int'(e.p));
            chk($sformatf("m%0d_framing", k), int'(fr_ok), 1);
            if (e.b2b) chk($sformatf("m%0d_gap", k), st - last, fl);
          end
          last = st;
        end
      end
    end
  endtask

  initial mon(0, 8, 1'b0, 1, 100);
  initial mon(1, 8, 1'b1, 1, 110);
  initial mon(2, 7, 1'b1, 2, 110);

  initial begin
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    rst_n = 1'b0;
    rst0_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx0, 1);
    chk("rst_ack", ack0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_full", full0, 0);
    chk("rst_level", lvl0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rst0_n = 1'b1;
    repeat (2) @(negedge clk);

    // single 8N1 frame with exact edge timing
    en0 = 1'b1;
    d0 = 8'h55;
    q0.push_back(mk(9'h055, 1'b0, 1'b0));
    @(posedge clk); #1;
    chk("t1_ack", ack0, 1);
    chk("t1_level", lvl0, 1);
    en0 = 1'b0;
    d0 = 8'hFF;
    @(posedge clk); #1;
    chk("t1_ack_pulse", ack0, 0);
    chk("t1_busy_start", busy0, 1);
    chk("t1_tx_e1", tx0, 1);
    chk("t1_level_pop", lvl0, 0);
    @(posedge clk); #1;
    chk("t1_tx_e2", tx0, 0);
    repeat (98) @(posedge clk);
    #1;
    chk("t1_busy_e100", busy0, 1);
    @(posedge clk); #1;
    chk("t1_busy_e101", busy0, 0);
    repeat (20) @(negedge clk);

    // overfill: six writes, five accepted
    for (int i = 1; i <= 6; i++) begin
      en0 = 1'b1;
      d0 = 8'(i);
      if (i <= 5) q0.push_back(mk(9'(i), 1'b0, (i > 1)));
      @(posedge clk); #1;
      chk($sformatf("t3_ack%0d", i), ack0, (i <= 5) ? 1 : 0);
    end
    en0 = 1'b0;
    chk("t3_full", full0, 1);
    chk("t3_level", lvl0, 4);
    repeat (520) @(negedge clk);

    // push and pop on the same edge at level 2
    for (int i = 0; i < 3; i++) begin
      en0 = 1'b1;
      d0 = (i == 0) ? 8'hA1 : (i == 1) ? 8'hB2 : 8'hC3;
      q0.push_back(mk({1'b0, d0}, 1'b0, (i > 0)));
      @(posedge clk); #1;
      chk($sformatf("t6_ack%0d", i), ack0, 1);
    end
    en0 = 1'b0;
    chk("t6_level_a", lvl0, 2);
    repeat (98) @(posedge clk);
    #1;
    chk("t6_level_b", lvl0, 2);
    en0 = 1'b1;
    d0 = 8'hD4;
    q0.push_back(mk(9'h0D4, 1'b0, 1'b1));
    @(posedge clk); #1;
    chk("t6_ack_same", ack0, 1);
    chk("t6_level_same", lvl0, 2);
    en0 = 1'b0;
    repeat (420) @(negedge clk);

    // parity: even on u1, odd with 7 bits and 2 stops on u2
    en1 = 1'b1; d1 = 8'h07;
    en2 = 1'b1; d2 = 7'h07;
    q1.push_back(mk(9'h007, 1'b1, 1'b0));
    q2.push_back(mk(9'h007, 1'b0, 1'b0));
    @(posedge clk); #1;
    chk("t2_ack1", ack1, 1);
    chk("t2_ack2", ack2, 1);
    d1 = 8'h00;
    d2 = 7'h7F;
    q1.push_back(mk(9'h000, 1'b0, 1'b1));
    q2.push_back(mk(9'h07F, 1'b0, 1'b1));
    @(posedge clk); #1;
    en1 = 1'b0;
    d2 = 7'h00;
    q2.push_back(mk(9'h000, 1'b1, 1'b1));
    @(posedge clk); #1;
    en2 = 1'b0;
    repeat (360) @(negedge clk);

    // asynchronous reset in the middle of a frame
    for (int i = 0; i < 3; i++) begin
      en0 = 1'b1;
      d0 = 8'(i * 17);
      @(posedge clk); #1;
    end
    en0 = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("t5_pre_tx", tx0, 0);
    chk("t5_pre_level", lvl0, 2);
    rst0_n = 1'b0;
    #1;
    chk("t5_tx_async", tx0, 1);
    chk("t5_level", lvl0, 0);
    chk("t5_busy", busy0, 0);
    chk("t5_full", full0, 0);
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("t5_idle_busy", busy0, 0);
    chk("t5_idle_tx", tx0, 1);
    chk("t5_idle_level", lvl0, 0);
    en0 = 1'b1;
    d0 = 8'h3C;
    q0.push_back(mk(9'h03C, 1'b0, 1'b0));
    @(posedge clk); #1;
    chk("t5_ack_new", ack0, 1);
    en0 = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      if (q0.size() + q1.size() + q2.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drain", q0.size() + q1.size() + q2.size(), 0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
